mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage of the five-stage pipeline, between the EX/MEM boundary and the MEM/WB pipeline register. It takes the EX result (address or ALU value), runs loads and stores over a req/ack data-memory bus, and stalls upstream until the access completes. It then presents rd, result, formatted load data and Wreg to the MEM/WB register for one cycle.

## Interface
- No parameters.
- Clock  in  1  clock, rising edge
- nReset  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a valid instruction
- ex_rd  in  5  destination register
- ex_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_mem_read / ex_mem_write  in  1 each  load / store (never both)
- ex_funct3  in  3  access size/sign
- ex_Wreg  in  1  register write enable
- stall  out  1  hold EX/MEM and earlier stages
- rd, result, memOut  out  5/32/32  to MEM/WB register
- Wreg  out  1  write enable to MEM/WB register
- fault  out  1  one-cycle pulse, misaligned or illegal access
- dmem_req, dmem_we  out  1 each  bus request / write
- dmem_addr  out  32  word-aligned address ([1:0]=0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ack  in  1  request accepted and completed this cycle
- dmem_rdata  in  32  read word, valid with dmem_ack

## Operation
- Non-memory op, or ex_valid=0, in IDLE: outputs pass through combinationally (memOut=0, Wreg=ex_Wreg&ex_valid). stall=0.
- FSM states: IDLE, REQ1, REQ2, DONE.
- IDLE + valid mem op: stall=1. Latch rd, result, store data, funct3, Wreg. Go to REQ1, or to DONE with fault if the op is illegal or misaligned.
- REQ1: dmem_req=1 and bus fields held stable until ack. On ack: go to REQ2 if the access is split, else DONE. Load bytes from this ack are captured.
- REQ2: address = first word + 4, remaining byte enables. On ack go to DONE.
- DONE: stall=0. Outputs are the latched rd and result; memOut = formatted load data (0 for stores); Wreg = latched Wreg & ~fault & load. Next state is IDLE.
- funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For stores: 000 SB, 001 SH, 010 SW. Any other code is illegal: fault=1, no bus access.
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Store data is shifted to byte lane result[1:0]. dmem_be = size mask << result[1:0], truncated to the current word.
- dmem_ack outside REQ1/REQ2 is ignored.

## Timing
- Reset values: state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, fault=0; latched fields and outputs 0.
- Single access with ack in the first req cycle: op seen at cycle 0 (stall=1), req at cycle 1, DONE at cycle 2. Total 3 cycles, 2 of them stalled.
- Each wait cycle without ack adds 1 cycle. A split access adds at least 1 cycle.
- Fault path: cycle 0 IDLE, cycle 1 DONE with fault=1. No dmem_req is issued.
- nReset asserted mid-access: dmem_req drops immediately and the access is abandoned. No output is produced after reset.

## Configuration
- MEM_ACCESS_MISALIGNED_EN defined:
  - Any misaligned LH/LHU/SH/LW/SW is legal.
  - An access inside one word is a single access with shifted byte enables.
  - An access crossing a word boundary splits into REQ1 (low bytes, word at addr&~3) and REQ2 (high bytes, next word). Load bytes from both are merged.
- Not defined:
  - Any halfword access with addr[0]≠0 or word access with addr[1:0]≠0 gives fault=1, Wreg=0, no bus access.
  - REQ2 is unreachable and is not synthesised.

## Structure
- Shared package mem_access_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the size-mask function.
- One sub-module, load_format: combinational byte/half extraction and sign/zero extension from the merged 64-bit read window and offset.

## Test plan
- ADD with result 0x1234, rd=5, Wreg=1 -> same cycle result=0x1234, rd=5, Wreg=1, stall=0, no dmem_req.
- LB at 0x103, mem word 0x80AABBCC, ack in first req cycle -> dmem_addr=0x100, be=1000, memOut=0xFFFFFF80, 2 stall cycles.
- SH 0xBEEF at 0x202, ack after 3 wait cycles -> dmem_we=1, be=1100, wdata=0xBEEF0000, stall held 5 cycles, Wreg=0.
- LW at 0x301:
  - with MEM_ACCESS_MISALIGNED_EN: words 0x44332211 and 0x88776655 -> two requests (0x300 be=1110, 0x304 be=0001), memOut=0x55443322;
  - without it: fault=1, Wreg=0, no request.
- Illegal funct3=011 load -> fault pulse, no dmem_req, Wreg=0.
- nReset pulsed while in REQ1 waiting for ack -> dmem_req=0 immediately, state IDLE, stall=0, late dmem_ack ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, funct3 codes and size mask for the data-memory access stage
package mem_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ1 = 2'd1,
    S_REQ2 = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane mask for an access of the given size, anchored at lane 0.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_format.sv
// rtl/load_format.sv - extracts byte/half/word from the merged read window and sign/zero extends it
module load_format
  import mem_access_pkg::*;
(
  input  logic [63:0] window_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(window_i >> {offset_i, 3'b000});
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'b0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'b0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage load/store FSM over a req/ack bus; MEM_ACCESS_MISALIGNED_EN enables split misaligned accesses
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_Wreg,
  output logic        stall,
  output logic [4:0]  rd,
  output logic [31:0] result,
  output logic [31:0] memOut,
  output logic        Wreg,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic        wreg_q, wreg_d;
  logic        load_q, load_d;
  logic        fault_q, fault_d;

  logic        mem_op;
  logic        legal;
  logic        aligned;
  logic [3:0]  be_lo;
  logic [31:0] wd_lo;
  logic [63:0] window;
  logic [31:0] load_data;
  logic [31:0] word_addr;

  assign mem_op    = ex_valid & (ex_mem_read | ex_mem_write);
  assign word_addr = {result_q[31:2], 2'b00};

  always_comb begin
    case (ex_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ex_mem_read;
      default:          legal = 1'b0;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGNED_EN
  logic [31:0] hi_q, hi_d;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [3:0]  be_hi;
  logic [31:0] wd_hi;
  logic        split;

  // Lanes pushed past byte 3 belong to the following word.
  assign be_wide = {4'b0, size_mask(f3_q[1:0])} << result_q[1:0];
  assign wd_wide = {32'b0, sdata_q} << {result_q[1:0], 3'b000};
  assign be_lo   = be_wide[3:0];
  assign be_hi   = be_wide[7:4];
  assign wd_lo   = wd_wide[31:0];
  assign wd_hi   = wd_wide[63:32];
  assign split   = |be_hi;
  assign aligned = 1'b1;
  assign window  = {hi_q, lo_q};
`else
  assign be_lo  = size_mask(f3_q[1:0]) << result_q[1:0];
  assign wd_lo  = sdata_q << {result_q[1:0], 3'b000};
  assign window = {32'b0, lo_q};

  always_comb begin
    case (ex_funct3[1:0])
      2'b01:   aligned = ~ex_result[0];
      2'b10:   aligned = (ex_result[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end
`endif

  load_format u_load_format (
    .window_i (window),
    .offset_i (result_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    result_d   = result_q;
    sdata_d    = sdata_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    wreg_d     = wreg_q;
    load_d     = load_q;
    fault_d    = fault_q;
`ifdef MEM_ACCESS_MISALIGNED_EN
    hi_d       = hi_q;
`endif
    stall      = 1'b0;
    rd         = rd_q;
    result     = result_q;
    memOut     = 32'b0;
    Wreg       = 1'b0;
    fault      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'b0;
    dmem_be    = 4'b0;
    dmem_wdata = 32'b0;

    case (state_q)
      S_IDLE: begin
        rd     = ex_rd;
        result = ex_result;
        Wreg   = ex_Wreg & ex_valid;
        if (mem_op) begin
          stall    = 1'b1;
          Wreg     = 1'b0;
          rd_d     = ex_rd;
          result_d = ex_result;
          sdata_d  = ex_store_data;
          f3_d     = ex_funct3;
          wreg_d   = ex_Wreg;
          load_d   = ex_mem_read;
          fault_d  = ~(legal & aligned);
          state_d  = (legal & aligned) ? S_REQ1 : S_DONE;
        end
      end
      S_REQ1: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = ~load_q;
        dmem_addr  = word_addr;
        dmem_be    = be_lo;
        dmem_wdata = load_q ? 32'b0 : wd_lo;
        if (dmem_ack) begin
          lo_d = dmem_rdata;
`ifdef MEM_ACCESS_MISALIGNED_EN
          state_d = split ? S_REQ2 : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MEM_ACCESS_MISALIGNED_EN
      S_REQ2: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = ~load_q;
        dmem_addr  = word_addr + 32'd4;
        dmem_be    = be_hi;
        dmem_wdata = load_q ? 32'b0 : wd_hi;
        if (dmem_ack) begin
          hi_d    = dmem_rdata;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        memOut  = (load_q & ~fault_q) ? load_data : 32'b0;
        Wreg    = wreg_q & load_q & ~fault_q;
        fault   = fault_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      rd_q     <= 5'b0;
      result_q <= 32'b0;
      sdata_q  <= 32'b0;
      lo_q     <= 32'b0;
      f3_q     <= 3'b0;
      wreg_q   <= 1'b0;
      load_q   <= 1'b0;
      fault_q  <= 1'b0;
`ifdef MEM_ACCESS_MISALIGNED_EN
      hi_q     <= 32'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      sdata_q  <= sdata_d;
      lo_q     <= lo_d;
      f3_q     <= f3_d;
      wreg_q   <= wreg_d;
      load_q   <= load_d;
      fault_q  <= fault_d;
`ifdef MEM_ACCESS_MISALIGNED_EN
      hi_q     <= hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit with a wait-state memory responder
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        ex_Wreg;
  logic        stall;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] memOut;
  logic        Wreg;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  mem_access_unit dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_Wreg       (ex_Wreg),
    .stall         (stall),
    .rd            (rd),
    .result        (result),
    .memOut        (memOut),
    .Wreg          (Wreg),
    .fault         (fault),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] result;
    logic [31:0] mem_out;
    logic [31:0] wreg;
    logic [31:0] fault;
    logic [31:0] stalls;
  } out_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] be;
    logic [31:0] we;
    logic [31:0] wdata;
  } bus_t;

  out_t        exp_out[$];
  bus_t        exp_bus[$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          bus_waits = 0;
  int          wait_cnt  = 0;
  logic        stray_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  task automatic exp_req(input logic [31:0] addr, input logic [31:0] be,
                         input logic [31:0] we, input logic [31:0] wdata);
    bus_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
    exp_bus.push_back(b);
  endtask

  // Memory responder: acks after bus_waits idle request cycles, checks each accepted request.
  initial begin
    bus_t b;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge Clock);
      if (dmem_req && wait_cnt >= bus_waits) begin
        dmem_ack   = 1'b1;
        dmem_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
        wait_cnt   = 0;
        n_tests++;
        assert (exp_bus.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_req: got addr 0x%08h be %b expected no request", dmem_addr, dmem_be);
        end
        if (exp_bus.size() != 0) begin
          b = exp_bus.pop_front();
          check("bus_addr", dmem_addr, b.addr);
          check("bus_be", 32'(dmem_be), b.be);
          check("bus_we", 32'(dmem_we), b.we);
          check("bus_wdata", dmem_wdata, b.wdata);
        end
      end else begin
        dmem_ack   = stray_ack;
        dmem_rdata = 32'hDEAD0000;
        if (dmem_req) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] rd_en, input logic [31:0] wr_en, input logic [31:0] f3,
                       input logic [31:0] rdn, input logic [31:0] res, input logic [31:0] sd,
                       input logic [31:0] wreg, input logic [31:0] e_mem, input logic [31:0] e_wreg,
                       input logic [31:0] e_fault, input logic [31:0] e_stalls);
    out_t e;
    int   cycles;
    e.rd = rdn; e.result = res; e.mem_out = e_mem;
    e.wreg = e_wreg; e.fault = e_fault; e.stalls = e_stalls;
    exp_out.push_back(e);
    @(negedge Clock);
    ex_valid      = 1'b1;
    ex_mem_read   = rd_en[0];
    ex_mem_write  = wr_en[0];
    ex_funct3     = f3[2:0];
    ex_rd         = rdn[4:0];
    ex_result     = res;
    ex_store_data = sd;
    ex_Wreg       = wreg[0];
    cycles = 0;
    #1;
    while (stall && cycles < 50) begin
      cycles++;
      @(negedge Clock);
      #1;
    end
    e = exp_out.pop_front();
    check("stall_cycles", cycles, e.stalls);
    check("rd", 32'(rd), e.rd);
    check("result", result, e.result);
    check("memOut", memOut, e.mem_out);
    check("Wreg", 32'(Wreg), e.wreg);
    check("fault", 32'(fault), e.fault);
    @(negedge Clock);
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    #1;
    check("fault_pulse_end", 32'(fault), 0);
    check("bus_drained", exp_bus.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_result = 32'h0; ex_store_data = 32'h0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000; ex_Wreg = 1'b0;
    mem[32'h100] = 32'h80AABBCC;
    mem[32'h300] = 32'h44332211;
    mem[32'h304] = 32'h88776655;

    repeat (2) @(negedge Clock);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", 32'(dmem_be), 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_memOut", memOut, 0);
    check("rst_Wreg", 32'(Wreg), 0);
    @(negedge Clock);
    nReset = 1'b1;

    // ADD passthrough
    issue(0, 0, 3'b000, 5, 32'h1234, 0, 1, 32'h0, 1, 0, 0);
    // LB 0x103
    exp_req(32'h100, 4'b1000, 0, 32'h0);
    issue(1, 0, 3'b000, 7, 32'h103, 0, 1, 32'hFFFFFF80, 1, 0, 2);
    // SH 0xBEEF at 0x202, 3 wait cycles
    bus_waits = 3;
    exp_req(32'h200, 4'b1100, 1, 32'hBEEF0000);
    issue(0, 1, 3'b001, 3, 32'h202, 32'h1234BEEF, 1, 32'h0, 0, 0, 5);
    bus_waits = 0;
    // LW 0x301
`ifdef MEM_ACCESS_MISALIGNED_EN
    exp_req(32'h300, 4'b1110, 0, 32'h0);
    exp_req(32'h304, 4'b0001, 0, 32'h0);
    issue(1, 0, 3'b010, 9, 32'h301, 0, 1, 32'h55443322, 1, 0, 3);
`else
    issue(1, 0, 3'b010, 9, 32'h301, 0, 1, 32'h0, 0, 1, 1);
`endif
    // illegal load funct3
    issue(1, 0, 3'b011, 10, 32'h400, 0, 1, 32'h0, 0, 1, 1);
    // LHU / LH / LBU
    exp_req(32'h100, 4'b1100, 0, 32'h0);
    issue(1, 0, 3'b101, 11, 32'h102, 0, 1, 32'h000080AA, 1, 0, 2);
    exp_req(32'h100, 4'b1100, 0, 32'h0);
    issue(1, 0, 3'b001, 12, 32'h102, 0, 1, 32'hFFFF80AA, 1, 0, 2);
    exp_req(32'h100, 4'b0010, 0, 32'h0);
    issue(1, 0, 3'b100, 13, 32'h101, 0, 1, 32'h000000BB, 1, 0, 2);
    // SB with one wait cycle, SW aligned
    bus_waits = 1;
    exp_req(32'h500, 4'b1000, 1, 32'hA5000000);
    issue(0, 1, 3'b000, 0, 32'h503, 32'hFFFFFFA5, 0, 32'h0, 0, 0, 3);
    bus_waits = 0;
    exp_req(32'h600, 4'b1111, 1, 32'hDEADBEEF);
    issue(0, 1, 3'b010, 0, 32'h600, 32'hDEADBEEF, 0, 32'h0, 0, 0, 2);
    // store with an unsigned-load code is illegal
    issue(0, 1, 3'b100, 0, 32'h700, 32'h11, 0, 32'h0, 0, 1, 1);
    // SH at odd address inside one word
`ifdef MEM_ACCESS_MISALIGNED_EN
    exp_req(32'h200, 4'b0110, 1, 32'h00BEEF00);
    issue(0, 1, 3'b001, 0, 32'h201, 32'h0000BEEF, 0, 32'h0, 0, 0, 2);
`else
    issue(0, 1, 3'b001, 0, 32'h201, 32'h0000BEEF, 0, 32'h0, 0, 1, 1);
`endif

    // reset while REQ1 is waiting for ack
    bus_waits = 1000;
    @(negedge Clock);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'b010; ex_rd = 5'd4; ex_result = 32'h100; ex_Wreg = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    check("abort_req_before", 32'(dmem_req), 1);
    #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    nReset = 1'b0;
    #1;
    check("abort_req", 32'(dmem_req), 0);
    check("abort_stall", 32'(stall), 0);
    @(negedge Clock);
    nReset = 1'b1;
    bus_waits = 0;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      #1;
      check("late_ack_stall", 32'(stall), 0);
      check("late_ack_req", 32'(dmem_req), 0);
      check("late_ack_Wreg", 32'(Wreg), 0);
    end
    stray_ack = 1'b0;
    @(negedge Clock);

    // recovery after reset
    exp_req(32'h100, 4'b1111, 0, 32'h0);
    issue(1, 0, 3'b010, 1, 32'h100, 0, 1, 32'h80AABBCC, 1, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
